// File: rtl/dmem_responder_if.sv
// Load/store request/response handshake between the core's memory stage and the data-memory responder.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: fixed access latency, lane-masked stores,
// sign/zero-extended loads, and error reporting for misaligned, illegal-size and out-of-range accesses.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    req_t             r_req;
    logic             r_req_ready;
    logic             r_rsp_valid;
    logic [31:0]      r_rsp_rdata;
    logic             r_rsp_error;
    logic [31:0]      r_mem [DEPTH_WORDS];

    req_t             w_in;
    req_t             w_cur;
    logic             w_accept;
    logic             w_commit;
    logic             w_error;
    logic             w_we;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_word;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load;
    logic [31:0]      w_rsp_rdata;
    logic [3:0]       w_be;
    logic [31:0]      w_wlanes;

    assign w_in = '{write: bus.req_write, addr: bus.req_addr, size: bus.req_size,
                    uns: bus.req_unsigned, wdata: bus.req_wdata};

    // With LATENCY=1 the commit edge is the acceptance edge, so the live request is used directly.
    assign w_cur    = (r_state == S_IDLE) ? w_in : r_req;
    assign w_accept = bus.req_valid && r_req_ready;
    assign w_commit = ((r_state == S_IDLE) && w_accept && (LATENCY <= 1)) ||
                      ((r_state == S_WAIT) && (r_cnt == CNT_W'(1)));

    assign w_error  = (w_cur.size == 2'b11) ||
                      ((w_cur.size == 2'b01) && w_cur.addr[0]) ||
                      ((w_cur.size == 2'b10) && (w_cur.addr[1:0] != 2'b00)) ||
                      (w_cur.addr[31:2] >= 30'(DEPTH_WORDS));
    assign w_idx    = w_cur.addr[IDX_W+1:2];
    assign w_word   = r_mem[w_idx];
    assign w_we     = w_commit && w_cur.write && !w_error;

    // Load lane extraction and extension.
    always_comb begin
        w_byte = w_word[7:0];
        case (w_cur.addr[1:0])
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            2'd3:    w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
        w_half = w_cur.addr[1] ? w_word[31:16] : w_word[15:0];
        case (w_cur.size)
            2'b00:   w_load = w_cur.uns ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load = w_cur.uns ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
        w_rsp_rdata = (w_error || w_cur.write) ? 32'b0 : w_load;
    end

    // Store byte enables and replicated lane data.
    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = w_cur.wdata;
        case (w_cur.size)
            2'b00: begin
                w_be     = 4'b0001 << w_cur.addr[1:0];
                w_wlanes = {4{w_cur.wdata[7:0]}};
            end
            2'b01: begin
                w_be     = w_cur.addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{w_cur.wdata[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // Data RAM: contents intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_req       <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'b0;
            r_rsp_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_req       <= w_in;
                        r_cnt       <= CNT_W'(LATENCY - 1);
                        r_req_ready <= 1'b0;
                        if (w_commit) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= w_rsp_rdata;
                            r_rsp_error <= w_error;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_commit) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_rsp_rdata;
                        r_rsp_error <= w_error;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_req_ready <= 1'b1;
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= 32'b0;
                        r_rsp_error <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_rsp_rdata <= 32'b0;
                    r_rsp_error <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_error = r_rsp_error;
endmodule
